// File: rtl/rt_lim_pkg.sv
// Shared types and geometry helpers for the racetrack logic-in-memory line.
package rt_lim_pkg;

  typedef enum logic [1:0] {
    RT_OP_READ  = 2'd0,
    RT_OP_WRITE = 2'd1,
    RT_OP_LIM   = 2'd2
  } rt_op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } rt_state_e;

  function automatic int rt_nsp(input int nb, input int np);
    return nb / np;
  endfunction

  function automatic int rt_nov(input int nb, input int np);
    return nb / np - 1;
  endfunction

  // Overhead cells sit below port 0, so each port is offset by NOV.
  function automatic int rt_port_cell(input int nb, input int np, input int p);
    return p * rt_nsp(nb, np) + rt_nov(nb, np);
  endfunction

endpackage

// File: rtl/rt_lim_line_ctrl_if.sv
// Core-side LIM memory port of the racetrack line controller.
interface rt_lim_line_ctrl_if #(
  parameter int NB = 32,
  parameter int NP = 8,
  parameter int NT = 3
);
  localparam int PW = $clog2(NB / NP);
  localparam int TW = $clog2(NT + 1);

  logic          req_i;
  logic          ready_o;
  logic [1:0]    op_i;
  logic [TW-1:0] track_i;
  logic [PW-1:0] offset_i;
  logic [NP-1:0] wdata_i;
  logic [NP-1:0] wen_i;
  logic          rvalid_o;
  logic [NP-1:0] rdata_o;
  logic          err_o;
  logic [PW-1:0] pos_o;
  logic          shift_o;
  logic          shift_dir_o;

  modport master (
    output req_i, op_i, track_i, offset_i, wdata_i, wen_i,
    input  ready_o, rvalid_o, rdata_o, err_o, pos_o, shift_o, shift_dir_o
  );

  modport slave (
    input  req_i, op_i, track_i, offset_i, wdata_i, wen_i,
    output ready_o, rvalid_o, rdata_o, err_o, pos_o, shift_o, shift_dir_o
  );
endinterface

// File: rtl/rt_track.sv
// One racetrack: NB+NOV cells shifting as a unit, NP fixed access ports.
module rt_track
  import rt_lim_pkg::*;
#(
  parameter int NB = 32,
  parameter int NP = 8
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          shift_en,
  input  logic          shift_bwd,
  input  logic [NP-1:0] wen,
  input  logic [NP-1:0] wdata,
  output logic [NP-1:0] port
);
  localparam int NSP = rt_nsp(NB, NP);
  localparam int NOV = rt_nov(NB, NP);
  localparam int NC  = NB + NOV;

  logic [NC-1:0] cells;
  logic [NC-1:0] wmask;
  logic [NC-1:0] wbits;

  for (genvar c = 0; c < NC; c++) begin : g_cell
    if (c >= NOV && ((c - NOV) % NSP) == 0) begin : g_port_cell
      assign wmask[c] = wen[(c - NOV) / NSP];
      assign wbits[c] = wdata[(c - NOV) / NSP];
    end else begin : g_plain_cell
      assign wmask[c] = 1'b0;
      assign wbits[c] = 1'b0;
    end
  end

  for (genvar p = 0; p < NP; p++) begin : g_port
    assign port[p] = cells[rt_port_cell(NB, NP, p)];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cells <= '0;
    end else if (shift_en) begin
      cells <= shift_bwd ? {1'b0, cells[NC-1:1]} : {cells[NC-2:0], 1'b0};
    end else begin
      cells <= (cells & ~wmask) | (wbits & wmask);
    end
  end

endmodule

// File: rtl/rt_lim_line_ctrl.sv
// Racetrack LIM line: NT storage tracks plus shift/access controller.
// Define RT_LIM_EN to add the pNML NAND/NOR logic track and the LIM op.
module rt_lim_line_ctrl
  import rt_lim_pkg::*;
#(
  parameter int NB = 32,
  parameter int NP = 8,
  parameter int NT = 3
) (
  input logic               clk_i,
  input logic               rstn_i,
  rt_lim_line_ctrl_if.slave bus
);
  // state     | meaning
  // ST_IDLE   | ready, waiting for a request
  // ST_SHIFT  | one shift pulse per cycle until pos reaches offset
  // ST_ACCESS | read / write / LIM on the port cells
  // ST_RESP   | rvalid pulse carrying rdata/err
  localparam int NSP = rt_nsp(NB, NP);
  localparam int PW  = $clog2(NSP);
  localparam int TW  = $clog2(NT + 1);

  rt_state_e     state_q, state_d;
  logic [1:0]    op_q;
  logic [TW-1:0] trk_q;
  logic [PW-1:0] off_q, pos_q, pos_nxt;
  logic [NP-1:0] wdata_q, wen_q, rdata_q;
  logic          err_q;
  logic          ready, shifting, access, rvalid;
  logic          illegal, backward;
  logic [NP-1:0] lim_res;
  logic [NP-1:0] tport [NT+1];

  always_comb begin
    illegal = 1'b0;
    if (bus.op_i == 2'd3) illegal = 1'b1;
    if (int'(bus.track_i) > NT) illegal = 1'b1;
    if (bus.op_i == RT_OP_WRITE && int'(bus.track_i) == NT) illegal = 1'b1;
    if (int'(bus.offset_i) >= NSP) illegal = 1'b1;
`ifndef RT_LIM_EN
    if (bus.op_i == RT_OP_LIM || int'(bus.track_i) == NT) illegal = 1'b1;
`endif
  end

  assign backward = off_q > pos_q;
  assign pos_nxt  = backward ? pos_q + PW'(1) : pos_q - PW'(1);

  always_comb begin
    state_d  = state_q;
    ready    = 1'b0;
    shifting = 1'b0;
    access   = 1'b0;
    rvalid   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (bus.req_i) begin
          if (illegal)                    state_d = ST_RESP;
          else if (bus.offset_i != pos_q) state_d = ST_SHIFT;
          else                            state_d = ST_ACCESS;
        end
      end
      ST_SHIFT: begin
        shifting = 1'b1;
        if (pos_nxt == off_q) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        access  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rvalid  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      trk_q   <= '0;
      off_q   <= '0;
      wdata_q <= '0;
      wen_q   <= '0;
      pos_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (ready && bus.req_i) begin
        op_q    <= bus.op_i;
        trk_q   <= bus.track_i;
        off_q   <= bus.offset_i;
        wdata_q <= bus.wdata_i;
        wen_q   <= bus.wen_i;
        err_q   <= illegal;
        if (illegal) rdata_q <= '0;
      end
      if (shifting) pos_q <= pos_nxt;
      if (access) begin
        case (op_q)
          RT_OP_READ: rdata_q <= tport[trk_q];
          RT_OP_LIM:  rdata_q <= lim_res;
          default:    rdata_q <= '0;
        endcase
      end
    end
  end

  for (genvar t = 0; t < NT; t++) begin : g_trk
    rt_track #(.NB(NB), .NP(NP)) u_trk (
      .clk_i     (clk_i),
      .rstn_i    (rstn_i),
      .shift_en  (shifting),
      .shift_bwd (backward),
      .wen       ({NP{access && op_q == RT_OP_WRITE && int'(trk_q) == t}} & wen_q),
      .wdata     (wdata_q),
      .port      (tport[t])
    );
  end

`ifdef RT_LIM_EN
  // program bit selects NOR (1) or NAND (0) of data and mask
  assign lim_res = (tport[2] & ~(tport[0] | tport[1])) |
                   (~tport[2] & ~(tport[0] & tport[1]));

  rt_track #(.NB(NB), .NP(NP)) u_logic (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .shift_en  (shifting),
    .shift_bwd (backward),
    .wen       ({NP{access && op_q == RT_OP_LIM}}),
    .wdata     (lim_res),
    .port      (tport[NT])
  );
`else
  assign lim_res   = '0;
  assign tport[NT] = '0;
`endif

  assign bus.ready_o     = ready;
  assign bus.rvalid_o    = rvalid;
  assign bus.rdata_o     = rdata_q;
  assign bus.err_o       = err_q;
  assign bus.pos_o       = pos_q;
  assign bus.shift_o     = shifting;
  assign bus.shift_dir_o = shifting & backward;

endmodule

// File: tb/tb_rt_lim_line_ctrl.sv
// Self-checking bench for rt_lim_line_ctrl: directed table, corner sequences, random vs. model.
module tb_rt_lim_line_ctrl;
  localparam int NB  = 32;
  localparam int NP  = 8;
  localparam int NT  = 3;
  localparam int NSP = NB / NP;
`ifdef RT_LIM_EN
  localparam bit LIM_ON = 1'b1;
`else
  localparam bit LIM_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  rt_lim_line_ctrl_if #(.NB(NB), .NP(NP), .NT(NT)) bus ();
  rt_lim_line_ctrl #(.NB(NB), .NP(NP), .NT(NT)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Logical-bit model: mem[t][b] is bit b of track t, independent of shift position.
  bit mem [NT+1][NB];
  int mpos;

  task automatic model_reset();
    for (int t = 0; t <= NT; t++)
      for (int b = 0; b < NB; b++) mem[t][b] = 1'b0;
    mpos = 0;
  endtask

  task automatic model(input int op, input int trk, input int off,
                       input logic [7:0] wd, input logic [7:0] wm,
                       output logic [7:0] rd, output bit er, output int lat,
                       output int sh, output bit dir);
    bit legal;
    int d, b;
    legal = op != 3 && trk <= NT && !(op == 1 && trk == NT) && off < NSP &&
            (LIM_ON || (op != 2 && trk != NT));
    rd = '0; er = !legal; lat = 1; sh = 0; dir = 1'b0;
    if (legal) begin
      d   = (off > mpos) ? off - mpos : mpos - off;
      dir = off > mpos;
      sh  = d;
      lat = d + 2;
      for (int p = 0; p < NP; p++) begin
        b = p * NSP + off;
        case (op)
          0: rd[p] = mem[trk][b];
          1: if (wm[p]) mem[trk][b] = wd[p];
          default: begin
            mem[NT][b] = mem[2][b] ? !(mem[0][b] | mem[1][b]) : !(mem[0][b] & mem[1][b]);
            rd[p] = mem[NT][b];
          end
        endcase
      end
      mpos = off;
    end
  endtask

  // Issue one request at a negedge with ready high, follow it to its response.
  task automatic apply(input string tag, input int op, input int trk, input int off,
                       input logic [7:0] wd, input logic [7:0] wm, input bit junk,
                       input bit dir, input logic [7:0] erd, input bit eer,
                       input int elat, input int esh);
    int cyc = 0, rv = -1, nsh = 0, bad_dir = 0, bad_rdy = 0;
    logic [7:0] rd = '0;
    logic er = 1'b0;
    bus.req_i = 1'b1; bus.op_i = 2'(op); bus.track_i = 2'(trk);
    bus.offset_i = 2'(off); bus.wdata_i = wd; bus.wen_i = wm;
    while (rv < 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.ready_o) bad_rdy++;
      if (bus.shift_o) begin
        nsh++;
        if (bus.shift_dir_o != dir) bad_dir++;
      end
      if (bus.rvalid_o) begin
        rv = cyc; rd = bus.rdata_o; er = bus.err_o;
      end
      if (rv < 0 && junk) begin
        bus.req_i = 1'($urandom); bus.op_i = 2'($urandom); bus.track_i = 2'($urandom);
        bus.offset_i = 2'($urandom); bus.wdata_i = 8'($urandom); bus.wen_i = 8'($urandom);
      end else begin
        bus.req_i = 1'b0;
      end
    end
    @(negedge clk);
    chk($sformatf("%s rvalid_cycle", tag), rv, elat);
    chk($sformatf("%s err", tag), int'(er), int'(eer));
    chk($sformatf("%s rdata", tag), int'(rd), int'(erd));
    chk($sformatf("%s shifts", tag), nsh, esh);
    chk($sformatf("%s wrong_dir", tag), bad_dir, 0);
    chk($sformatf("%s ready_while_busy", tag), bad_rdy, 0);
    chk($sformatf("%s ready_after", tag), int'(bus.ready_o), 1);
    chk($sformatf("%s rvalid_after", tag), int'(bus.rvalid_o), 0);
    chk($sformatf("%s pos", tag), int'(bus.pos_o), mpos);
  endtask

  typedef struct {
    int op, trk, off;
    logic [7:0] wd, wm, rd;
    bit er;
    int lat, sh;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int op, input int trk, input int off, input logic [7:0] wd,
                     input logic [7:0] wm, input logic [7:0] rd, input bit er,
                     input int lat, input int sh);
    vec_t v;
    v.op = op; v.trk = trk; v.off = off; v.wd = wd; v.wm = wm;
    v.rd = rd; v.er = er; v.lat = lat; v.sh = sh;
    tbl.push_back(v);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_rd, wd, wm;
    bit m_er, m_dir;
    int m_lat, m_sh, nrv, op, trk, off, r;

    bus.req_i = 1'b0; bus.op_i = '0; bus.track_i = '0;
    bus.offset_i = '0; bus.wdata_i = '0; bus.wen_i = '0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    model_reset();
    @(negedge clk);
    chk("reset ready", int'(bus.ready_o), 1);
    chk("reset pos", int'(bus.pos_o), 0);
    chk("reset rvalid", int'(bus.rvalid_o), 0);
    chk("reset shift", int'(bus.shift_o), 0);
    chk("reset err", int'(bus.err_o), 0);
    chk("reset rdata", int'(bus.rdata_o), 0);

    //  op trk off wdata  wen    rdata  err lat sh
    add(0, 0, 0, 8'h00, 8'h00, 8'h00, 0, 2, 0);
    add(1, 0, 0, 8'hA5, 8'hFF, 8'h00, 0, 2, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 2, 0);
    add(1, 0, 3, 8'h3C, 8'hFF, 8'h00, 0, 5, 3);
    add(0, 0, 0, 8'h00, 8'h00, 8'hA5, 0, 5, 3);
    add(0, 0, 3, 8'h00, 8'h00, 8'h3C, 0, 5, 3);
    add(1, 0, 1, 8'h00, 8'hFF, 8'h00, 0, 4, 2);
    add(1, 0, 1, 8'hFF, 8'h0F, 8'h00, 0, 2, 0);
    add(0, 0, 1, 8'h00, 8'h00, 8'h0F, 0, 2, 0);
    add(3, 0, 2, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    add(0, 0, 1, 8'h00, 8'h00, 8'h0F, 0, 2, 0);
    add(1, 1, 1, 8'hCC, 8'hFF, 8'h00, 0, 2, 0);
    add(1, 0, 1, 8'hF0, 8'hFF, 8'h00, 0, 2, 0);
    add(1, 2, 1, 8'hAA, 8'hFF, 8'h00, 0, 2, 0);
    add(1, 3, 1, 8'h55, 8'hFF, 8'h00, 1, 1, 0);
    add(2, 0, 1, 8'h00, 8'h00, LIM_ON ? 8'h17 : 8'h00, !LIM_ON, LIM_ON ? 2 : 1, 0);
    add(0, 3, 1, 8'h00, 8'h00, LIM_ON ? 8'h17 : 8'h00, !LIM_ON, LIM_ON ? 2 : 1, 0);
    add(2, 0, 2, 8'h00, 8'h00, LIM_ON ? 8'hFF : 8'h00, !LIM_ON, LIM_ON ? 3 : 1, LIM_ON ? 1 : 0);
    add(0, 3, 2, 8'h00, 8'h00, LIM_ON ? 8'hFF : 8'h00, !LIM_ON, LIM_ON ? 2 : 1, 0);
    add(0, 0, 0, 8'h00, 8'h00, 8'hA5, 0, LIM_ON ? 4 : 3, LIM_ON ? 2 : 1);

    foreach (tbl[i]) begin
      model(tbl[i].op, tbl[i].trk, tbl[i].off, tbl[i].wd, tbl[i].wm, m_rd, m_er, m_lat, m_sh, m_dir);
      apply($sformatf("tbl%0d", i), tbl[i].op, tbl[i].trk, tbl[i].off, tbl[i].wd, tbl[i].wm,
            1'b0, m_dir, tbl[i].rd, tbl[i].er, tbl[i].lat, tbl[i].sh);
    end

    // Reset in the middle of a 0 -> 3 shift: response dropped, cells and pos cleared.
    model(1, 0, 0, 8'h5A, 8'hFF, m_rd, m_er, m_lat, m_sh, m_dir);
    apply("pre_rst", 1, 0, 0, 8'h5A, 8'hFF, 1'b0, m_dir, 8'h00, 1'b0, 2, 0);
    bus.req_i = 1'b1; bus.op_i = 2'd0; bus.track_i = 2'd0; bus.offset_i = 2'd3;
    @(negedge clk);
    bus.req_i = 1'b0;
    chk("midrst shift_c1", int'(bus.shift_o), 1);
    chk("midrst dir_c1", int'(bus.shift_dir_o), 1);
    @(negedge clk);
    chk("midrst pos_c2", int'(bus.pos_o), 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst pos_in_rst", int'(bus.pos_o), 0);
    chk("midrst ready_in_rst", int'(bus.ready_o), 1);
    chk("midrst shift_in_rst", int'(bus.shift_o), 0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    nrv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.rvalid_o) nrv++;
    end
    chk("midrst no_rvalid", nrv, 0);
    chk("midrst ready", int'(bus.ready_o), 1);
    chk("midrst pos", int'(bus.pos_o), 0);
    model(0, 0, 0, 8'h00, 8'h00, m_rd, m_er, m_lat, m_sh, m_dir);
    apply("post_rst_rd0", 0, 0, 0, 8'h00, 8'h00, 1'b0, m_dir, 8'h00, 1'b0, 2, 0);
    model(0, 0, 3, 8'h00, 8'h00, m_rd, m_er, m_lat, m_sh, m_dir);
    apply("post_rst_rd3", 0, 0, 3, 8'h00, 8'h00, 1'b0, m_dir, 8'h00, 1'b0, 5, 3);

    for (int k = 0; k < 300; k++) begin
      r   = $urandom_range(0, 7);
      op  = (r < 3) ? 0 : (r < 6) ? 1 : (r == 6) ? 2 : 3;
      trk = $urandom_range(0, NT);
      off = $urandom_range(0, NSP - 1);
      wd  = 8'($urandom);
      wm  = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      model(op, trk, off, wd, wm, m_rd, m_er, m_lat, m_sh, m_dir);
      apply($sformatf("rnd%0d", k), op, trk, off, wd, wm, 1'($urandom_range(0, 1)),
            m_dir, m_rd, m_er, m_lat, m_sh);
      if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
